// File: rtl/match_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_pkg                                                            |
// | Shared state codes, winner codes and score helpers for match_ctrl.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package match_pkg;

    localparam int SCORE_W = 4;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SERVE      = 3'd1;
    localparam logic [2:0] ST_RALLY      = 3'd2;
    localparam logic [2:0] ST_SCORED     = 3'd3;
    localparam logic [2:0] ST_PAUSE      = 3'd4;
    localparam logic [2:0] ST_MATCH_OVER = 3'd5;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // A side wins at or above the target with enough lead, or on reaching the score cap.
    function automatic logic has_won(
        input logic        [SCORE_W-1:0] mine,
        input logic        [SCORE_W-1:0] other,
        input logic        [SCORE_W-1:0] win_score,
        input logic signed [SCORE_W:0]   min_lead
    );
        logic signed [SCORE_W:0] lead;
        lead = $signed({1'b0, mine}) - $signed({1'b0, other});
        return (mine >= win_score) &&
               ((lead >= min_lead) || (mine == {SCORE_W{1'b1}}));
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_divider                                                        |
// | Free-running divider producing a one-cycle tick every FRAME_DIV clks.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_divider #(
    parameter int FRAME_DIV = 833334
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_ctrl                                                           |
// | Serve/rally/pause sequencer gating the physics step once per frame.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module match_ctrl
    import match_pkg::*;
#(
    parameter int FRAME_DIV    = 833334,
    parameter int SERVE_FRAMES = 60,
    parameter int PAUSE_FRAMES = 90,
    parameter int WIN_SCORE    = 7,
    parameter int MIN_LEAD     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               point_evt_i,
    input  logic [SCORE_W-1:0] p1_score_i,
    input  logic [SCORE_W-1:0] p2_score_i,
    output logic               frame_tick_o,
    output logic               phys_en_o,
    output logic               phys_clear_o,
    output logic               serve_side_o,
    output logic [2:0]         state_o,
    output logic [1:0]         winner_o,
    output logic               match_over_o
);

    localparam logic [7:0]                c_SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]                c_PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [SCORE_W-1:0]        c_WIN_SCORE  = SCORE_W'(WIN_SCORE);
    localparam logic signed [SCORE_W:0]   c_MIN_LEAD   = 5'(MIN_LEAD);

    logic               w_tick;
    logic [2:0]         r_state;
    logic [7:0]         r_frame_cnt2;
    logic [7:0]         w_cnt_inc;
    logic               r_phys_clear;
    logic               r_serve_side;
    logic [1:0]         r_winner;
    logic [SCORE_W-1:0] r_snap_p1;
    logic [SCORE_W-1:0] r_snap_p2;
    logic               w_p1_up;
    logic               w_p2_up;
    logic               w_p1_win;
    logic               w_p2_win;

    frame_divider #(
        .FRAME_DIV(FRAME_DIV)
    ) u_frame_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_cnt_inc = (r_frame_cnt2 == 8'hFF) ? r_frame_cnt2 : r_frame_cnt2 + 8'd1;
    assign w_p1_up   = (p1_score_i > r_snap_p1);
    assign w_p2_up   = (p2_score_i > r_snap_p2);
    assign w_p1_win  = has_won(p1_score_i, p2_score_i, c_WIN_SCORE, c_MIN_LEAD);
    assign w_p2_win  = has_won(p2_score_i, p1_score_i, c_WIN_SCORE, c_MIN_LEAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_cnt2 <= 8'd0;
            r_phys_clear <= 1'b0;
            r_serve_side <= 1'b0;
            r_winner     <= WIN_NONE;
            r_snap_p1    <= '0;
            r_snap_p2    <= '0;
        end else begin
            r_phys_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state      <= ST_SERVE;
                        r_phys_clear <= 1'b1;
                        r_frame_cnt2 <= 8'd0;
                        r_serve_side <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (w_tick) begin
                        if (r_frame_cnt2 == c_SERVE_LAST) begin
                            r_state      <= ST_RALLY;
                            r_frame_cnt2 <= 8'd0;
                        end else begin
                            r_frame_cnt2 <= w_cnt_inc;
                        end
                    end
                end
                ST_RALLY: begin
                    if (point_evt_i) begin
                        r_state <= ST_SCORED;
                    end
                end
                ST_SCORED: begin
                    r_snap_p1 <= p1_score_i;
                    r_snap_p2 <= p2_score_i;
                    if (w_p2_up) begin
                        r_serve_side <= 1'b1;
                    end else if (w_p1_up) begin
                        r_serve_side <= 1'b0;
                    end
                    if (w_p1_win) begin
                        r_state  <= ST_MATCH_OVER;
                        r_winner <= WIN_P1;
                    end else if (w_p2_win) begin
                        r_state  <= ST_MATCH_OVER;
                        r_winner <= WIN_P2;
                    end else begin
                        r_state      <= ST_PAUSE;
                        r_frame_cnt2 <= 8'd0;
                    end
                end
                ST_PAUSE: begin
                    if (w_tick) begin
                        if (r_frame_cnt2 == c_PAUSE_LAST) begin
                            r_state      <= ST_SERVE;
                            r_phys_clear <= 1'b1;
                            r_frame_cnt2 <= 8'd0;
                        end else begin
                            r_frame_cnt2 <= w_cnt_inc;
                        end
                    end
                end
                ST_MATCH_OVER: begin
                    // Physics scores are reset by the top level; only local snapshots clear here.
                    if (start_i) begin
                        r_state      <= ST_SERVE;
                        r_phys_clear <= 1'b1;
                        r_winner     <= WIN_NONE;
                        r_snap_p1    <= '0;
                        r_snap_p2    <= '0;
                        r_frame_cnt2 <= 8'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_tick_o = w_tick;
    assign phys_en_o    = (r_state == ST_RALLY) && w_tick;
    assign phys_clear_o = r_phys_clear;
    assign serve_side_o = r_serve_side;
    assign state_o      = r_state;
    assign winner_o     = r_winner;
    assign match_over_o = (r_state == ST_MATCH_OVER);

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_match_ctrl                                                        |
// | Directed self-checking bench with a point-outcome scoreboard.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_match_ctrl;
    import match_pkg::*;

    localparam int FD = 4;
    localparam int SF = 2;
    localparam int PF = 3;
    localparam int WS = 7;
    localparam int ML = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pe = 1'b0;
    logic [3:0] p1 = 4'd0;
    logic [3:0] p2 = 4'd0;

    logic       frame_tick_o;
    logic       phys_en_o;
    logic       phys_clear_o;
    logic       serve_side_o;
    logic [2:0] state_o;
    logic [1:0] winner_o;
    logic       match_over_o;

    match_ctrl #(
        .FRAME_DIV(FD), .SERVE_FRAMES(SF), .PAUSE_FRAMES(PF),
        .WIN_SCORE(WS), .MIN_LEAD(ML)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .point_evt_i(pe),
        .p1_score_i(p1), .p2_score_i(p2),
        .frame_tick_o(frame_tick_o), .phys_en_o(phys_en_o),
        .phys_clear_o(phys_clear_o), .serve_side_o(serve_side_o),
        .state_o(state_o), .winner_o(winner_o), .match_over_o(match_over_o)
    );

    always #5 clk = ~clk;

    // Reference frame position, restarted by the same asynchronous reset.
    int m;
    always @(posedge clk or posedge rst) begin
        if (rst) m <= 0;
        else     m <= (m == FD - 1) ? 0 : m + 1;
    end

    typedef struct packed {
        logic [2:0] st;
        logic       ss;
        logic [1:0] win;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   en_mode = 0;
    int   sb1 = 0;
    int   sb2 = 0;
    logic exp_ss = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("frame_tick", frame_tick_o, (m == FD - 1));
        if (en_mode == 1)      chk("phys_en_rally", phys_en_o, (m == FD - 1));
        else if (en_mode == 2) chk("phys_en_off", phys_en_o, 0);
    endtask

    // Counts frame ticks from the current cycle until the phase should end.
    task automatic run_phase(input logic [2:0] cur, input logic [2:0] nxt, input int frames,
                             input string tag, input logic poke, input logic clr_exit);
        int ticks;
        ticks = 0;
        en_mode = 2;
        for (int i = 0; i < frames * FD + FD + 2; i++) begin
            if (m == FD - 1) ticks++;
            if (ticks == frames) begin
                step();
                chk({tag, "_exit_state"}, state_o, nxt);
                chk({tag, "_exit_clear"}, phys_clear_o, clr_exit);
                break;
            end
            if (i == 0 && poke) begin
                pe = 1'b1;
                start = 1'b1;
            end
            step();
            pe = 1'b0;
            start = 1'b0;
            chk({tag, "_hold_state"}, state_o, cur);
            chk({tag, "_hold_clear"}, phys_clear_o, 0);
        end
    endtask

    task automatic do_point(input int p1n, input int p2n, input logic align, input logic with_start);
        exp_t e;
        exp_t got;
        logic w1;
        logic w2;
        en_mode = 1;
        repeat (5) step();
        if (align) begin
            for (int k = 0; k < FD && m != FD - 1; k++) step();
            chk("phys_en_at_point", phys_en_o, 1);
        end
        p1 = 4'(p1n);
        p2 = 4'(p2n);
        pe = 1'b1;
        start = with_start;
        if (p2n > sb2)      exp_ss = 1'b1;
        else if (p1n > sb1) exp_ss = 1'b0;
        w1 = (p1n >= WS) && ((p1n - p2n) >= ML || p1n == 15);
        w2 = (p2n >= WS) && ((p2n - p1n) >= ML || p2n == 15);
        e.st  = (w1 || w2) ? ST_MATCH_OVER : ST_PAUSE;
        e.ss  = exp_ss;
        e.win = w1 ? WIN_P1 : (w2 ? WIN_P2 : WIN_NONE);
        sb_q.push_back(e);
        en_mode = 2;
        step();
        pe = 1'b0;
        start = 1'b0;
        chk("scored_state", state_o, ST_SCORED);
        step();
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            got = sb_q.pop_front();
            chk("point_state", state_o, got.st);
            chk("point_serve_side", serve_side_o, got.ss);
            chk("point_winner", winner_o, got.win);
            chk("point_match_over", match_over_o, (got.st == ST_MATCH_OVER));
        end
        sb1 = p1n;
        sb2 = p2n;
    endtask

    task automatic next_serve(input logic poke);
        run_phase(ST_PAUSE, ST_SERVE, PF, "pause", poke, 1'b1);
        run_phase(ST_SERVE, ST_RALLY, SF, "serve", 1'b0, 1'b0);
    endtask

    initial begin
        en_mode = 2;
        repeat (3) begin
            step();
            chk("reset_outputs", {frame_tick_o, phys_en_o, phys_clear_o, serve_side_o,
                                  state_o, winner_o, match_over_o}, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (i == 3) pe = 1'b1;
            step();
            pe = 1'b0;
            chk("idle_outputs", {phys_en_o, phys_clear_o, serve_side_o, state_o,
                                 winner_o, match_over_o}, 0);
        end

        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_state", state_o, ST_SERVE);
        chk("start_clear", phys_clear_o, 1);
        chk("start_serve_side", serve_side_o, 0);
        run_phase(ST_SERVE, ST_RALLY, SF, "serve1", 1'b1, 1'b0);

        do_point(0, 1, 1'b1, 1'b1);
        next_serve(1'b1);
        do_point(0, 5, 1'b0, 1'b0);
        next_serve(1'b0);
        do_point(6, 5, 1'b1, 1'b0);
        next_serve(1'b0);
        do_point(7, 5, 1'b0, 1'b0);

        en_mode = 2;
        repeat (3) begin
            step();
            chk("over_state", state_o, ST_MATCH_OVER);
            chk("over_winner", winner_o, WIN_P1);
            chk("over_flag", match_over_o, 1);
        end

        p1 = 4'd0;
        p2 = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        sb1 = 0;
        sb2 = 0;
        chk("restart_state", state_o, ST_SERVE);
        chk("restart_clear", phys_clear_o, 1);
        chk("restart_winner", winner_o, WIN_NONE);
        chk("restart_over", match_over_o, 0);
        run_phase(ST_SERVE, ST_RALLY, SF, "serve2", 1'b0, 1'b0);

        do_point(0, 6, 1'b0, 1'b0);
        next_serve(1'b0);
        do_point(6, 6, 1'b0, 1'b0);
        next_serve(1'b0);
        do_point(7, 6, 1'b1, 1'b0);
        next_serve(1'b0);

        en_mode = 1;
        step();
        for (int k = 0; k < FD && m != FD - 1; k++) step();
        chk("pre_reset_phys_en", phys_en_o, 1);
        en_mode = 2;
        #1 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {frame_tick_o, phys_en_o, phys_clear_o, serve_side_o,
                                    state_o, winner_o, match_over_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("restart_tick_1", frame_tick_o, 0);
        step();
        chk("restart_tick_2", frame_tick_o, 0);
        step();
        chk("restart_tick_3", frame_tick_o, 1);
        chk("post_reset_state", state_o, ST_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
Rally/match sequencer for the volleyball physics engine. Divides the system clock into a frame tick and gates the physics step to one update per frame. Sequences each point through serve, rally and point-pause phases, tracks serve side and detects match end. Sits between the top-level input/button logic and the physics block; drives its step-enable and ball-clear controls.

Parameters:
FRAME_DIV, 833334, clk cycles per frame (60 Hz at 50 MHz); minimum 2
SERVE_FRAMES, 60, frames the ball is held before the rally starts
PAUSE_FRAMES, 90, frames shown after a point before the next serve
WIN_SCORE, 7, score needed to win; must be in 1..15
MIN_LEAD, 2, winning margin required below score 15

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start_i  in  1  single-cycle start/restart request
point_evt_i  in  1  physics scoring pulse, high in the cycle the score registers update
p1_score_i  in  4  physics P1 score
p2_score_i  in  4  physics P2 score
frame_tick_o  out  1  one-cycle pulse every FRAME_DIV cycles
phys_en_o  out  1  physics step enable
phys_clear_o  out  1  one-cycle ball re-initialise request to physics
serve_side_o  out  1  0 = P1 serves, 1 = P2 serves
state_o  out  3  current FSM state code
winner_o  out  2  00 none, 01 P1, 10 P2
match_over_o  out  1  high while in MATCH_OVER

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0 on reset, and the FSM enters IDLE. Frame counter, pause/serve counters and score snapshots clear to 0.
- Frame counter: free-running from 0 to FRAME_DIV-1 and then wraps. frame_tick_o is high when count == FRAME_DIV-1. The counter runs in every state.
- State encodings: IDLE=0, SERVE=1, RALLY=2, SCORED=3, PAUSE=4, MATCH_OVER=5.
- IDLE: phys_en_o=0. start_i moves to SERVE, pulses phys_clear_o for 1 cycle, loads frame_cnt2=0 and sets serve_side_o=0.
- SERVE: phys_en_o=0. frame_cnt2 increments on each frame_tick. When frame_cnt2==SERVE_FRAMES-1 and a tick occurs, move to RALLY.
- RALLY: phys_en_o = frame_tick_o (same cycle, combinational AND with state). point_evt_i moves to SCORED on the next edge. On that same edge, phys_en_o is forced 0.
- SCORED (exactly 1 cycle): compare p1_score_i and p2_score_i with the snapshots.
  - A P1 increase sets serve_side_o=0. A P2 increase sets serve_side_o=1.
  - If neither score changed, serve_side_o is kept.
  - Update the snapshots.
  - Win check uses the new values: score ≥ WIN_SCORE and (lead ≥ MIN_LEAD or score == 15). A win moves to MATCH_OVER and sets winner_o. Otherwise move to PAUSE with frame_cnt2=0.
- PAUSE: phys_en_o=0. After PAUSE_FRAMES ticks, pulse phys_clear_o and go to SERVE with frame_cnt2=0.
- MATCH_OVER: match_over_o=1 and winner_o is held. start_i pulses phys_clear_o, clears winner_o and the snapshots, and goes to SERVE. The physics score reset belongs to top level and is outside this block.
- start_i is ignored in SERVE, RALLY, SCORED and PAUSE. point_evt_i is ignored outside RALLY.
- Simultaneous events:
  - point_evt_i with frame_tick in RALLY: phys_en_o is still asserted that cycle, and the transition to SCORED still happens.
  - start_i with point_evt_i in RALLY: the point wins.
- Reset mid-operation returns to IDLE within the same cycle (asynchronous). There is no partial phys_clear pulse.
- Counters: frame counter width is clog2(FRAME_DIV). frame_cnt2 width is 8 bits, saturating. Score comparison is 4-bit unsigned. The lead is computed as a 5-bit signed difference.

Decomposition:
- Package match_pkg holds:
  - the state enum/localparams (IDLE..MATCH_OVER);
  - the winner codes;
  - SCORE_W=4.
- One natural sub-module: frame_divider. It takes FRAME_DIV, has clk/rst inputs and a tick output. The top-level video timing reuses it.

Test Plan:
- Reset held 3 cycles: all outputs 0, state_o=0 → release; no output change until start_i.
- FRAME_DIV=4, SERVE_FRAMES=2: start_i at cycle 10.
  - phys_clear_o is high in cycle 10 only.
  - state_o=1 until the 2nd tick after entry, then state_o=2.
  - phys_en_o pulses every 4 cycles, aligned with frame_tick_o.
- In RALLY, point_evt_i with p2_score_i stepping 0→1: SCORED for 1 cycle, serve_side_o=1, then PAUSE. After PAUSE_FRAMES ticks, a phys_clear_o pulse and SERVE.
- Scores 6–5 with P1 point to 7–5, WIN_SCORE=7, MIN_LEAD=2: MATCH_OVER, winner_o=01, match_over_o=1. Same test at 7–6: PAUSE instead, no win.
- point_evt_i in IDLE, SERVE or PAUSE: no state change. start_i together with point_evt_i in RALLY → SCORED.
- rst asserted mid-RALLY with phys_en_o high: all outputs 0 immediately, IDLE; frame counter restarts at 0.
